// File: rtl/enoc_pkg.sv
// rtl/enoc_pkg.sv - shared router constants and types for the enoc switch allocator
// Contents: router port count and port index constants (c,n,e,s,w,u,d),
// the default downstream credit depth, and the crossbar select type.
package enoc_pkg;

  localparam int PORTS = 7;

  // Router port indices.
  localparam int C = 0;
  localparam int N = 1;
  localparam int E = 2;
  localparam int S = 3;
  localparam int W = 4;
  localparam int U = 5;
  localparam int D = 6;

  // Default downstream buffer depth per output.
  localparam int CREDITS = 4;

  localparam int SEL_W = $clog2(PORTS);
  typedef logic [SEL_W-1:0] port_sel_t;

endpackage

// File: rtl/enoc_rr_arbiter.sv
// rtl/enoc_rr_arbiter.sv - WIDTH-wide round-robin arbiter with its own priority pointer
// Ports:
//   clk, reset_n  clock, synchronous active-low reset (pointer returns to 0)
//   req_i         request vector, bit i = requester i
//   en_i          arbitration enable; when low no grant is issued and the pointer holds
//   gnt_o         one-hot grant (combinational)
module enoc_rr_arbiter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] req_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] gnt_o
);
  import enoc_pkg::*;

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  // One extra bit so ptr + offset never overflows before the wrap correction.
  logic [PW:0]   idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    if (en_i) begin
      // Scan from the pointer upward, wrapping modulo WIDTH; first requester wins.
      for (int k = 0; k < WIDTH; k++) begin
        idx = {1'b0, ptr_q} + (PW+1)'(k);
        if (idx >= (PW+1)'(WIDTH)) begin
          idx = idx - (PW+1)'(WIDTH);
        end
        if (!found && req_i[idx[PW-1:0]]) begin
          found                = 1'b1;
          gnt_o[idx[PW-1:0]]   = 1'b1;
          ptr_d = (idx == (PW+1)'(WIDTH-1)) ? '0 : idx[PW-1:0] + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/enoc_switch_allocator.sv
// rtl/enoc_switch_allocator.sv - per-router switch allocator with round-robin per output
// Optional feature macro: ENOC_CREDIT_EN (credit-based flow control instead of ready).
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   i_output_req    [input][output] one-hot (or zero) request rows from route calculators
//   i_en            downstream ready per output (without ENOC_CREDIT_EN)
//   i_credit        one-cycle credit-return pulse per output (with ENOC_CREDIT_EN)
//   o_input_grant   input i's head flit transfers this cycle
//   o_output_val    output o carries a valid flit this cycle
//   o_sel           crossbar select, winning input index per output
module enoc_switch_allocator #(
  parameter int PORTS   = enoc_pkg::PORTS,
  parameter int CREDITS = enoc_pkg::CREDITS
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [0:PORTS-1][0:PORTS-1]         i_output_req,
`ifdef ENOC_CREDIT_EN
  input  logic [0:PORTS-1]                    i_credit,
`else
  input  logic [0:PORTS-1]                    i_en,
`endif
  output logic [0:PORTS-1]                    o_input_grant,
  output logic [0:PORTS-1]                    o_output_val,
  output logic [0:PORTS-1][$clog2(PORTS)-1:0] o_sel
);
  import enoc_pkg::*;

  localparam int SW = $clog2(PORTS);

  logic [PORTS-1:0] col_req [PORTS];
  logic [PORTS-1:0] col_gnt [PORTS];
  logic [PORTS-1:0] elig;
  logic [PORTS-1:0] out_busy;

  // Column o of the request matrix is the request vector seen by output o.
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        col_req[o][i] = i_output_req[i][o];
      end
    end
  end

  // Gating with reset_n forces every grant (and so every output) low during reset.
  for (genvar o = 0; o < PORTS; o++) begin : g_arb
    enoc_rr_arbiter #(.WIDTH(PORTS)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req_i   (col_req[o]),
      .en_i    (elig[o] & reset_n),
      .gnt_o   (col_gnt[o])
    );
  end

`ifdef ENOC_CREDIT_EN
  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0] credit_q [PORTS];
  logic [CW-1:0] credit_d [PORTS];

  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      elig[o] = (credit_q[o] != '0);
    end
  end

  // A grant and a credit return in the same cycle cancel out.
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      credit_d[o] = credit_q[o];
      if (out_busy[o] && !i_credit[o]) begin
        credit_d[o] = credit_q[o] - CW'(1);
      end else if (!out_busy[o] && i_credit[o] && (credit_q[o] != CW'(CREDITS))) begin
        credit_d[o] = credit_q[o] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int o = 0; o < PORTS; o++) begin
        credit_q[o] <= CW'(CREDITS);
      end
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        credit_q[o] <= credit_d[o];
      end
    end
  end
`else
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      elig[o] = i_en[o];
    end
  end
`endif

  // Rows are one-hot, so each input wins at most one output and a plain OR
  // of all grant columns is the input-side pop.
  always_comb begin
    o_input_grant = '0;
    o_output_val  = '0;
    o_sel         = '0;
    out_busy      = '0;
    for (int o = 0; o < PORTS; o++) begin
      out_busy[o]     = |col_gnt[o];
      o_output_val[o] = out_busy[o];
      for (int i = 0; i < PORTS; i++) begin
        if (col_gnt[o][i]) begin
          o_input_grant[i] = 1'b1;
          o_sel[o]         = SW'(i);
        end
      end
    end
  end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// tb/tb_enoc_switch_allocator.sv - scoreboard bench for enoc_switch_allocator (either ENOC_CREDIT_EN build)
module tb_enoc_switch_allocator;

  localparam int P  = 7;
  localparam int CR = 4;
  localparam int SW = $clog2(P);
`ifdef ENOC_CREDIT_EN
  localparam bit USE_CREDIT = 1'b1;
`else
  localparam bit USE_CREDIT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [0:P-1][0:P-1]   req;
  logic [0:P-1]          en_or_cr;
  logic [0:P-1]          grant;
  logic [0:P-1]          val;
  logic [0:P-1][SW-1:0]  sel;

  always #5 clk = ~clk;

  enoc_switch_allocator #(.PORTS(P), .CREDITS(CR)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_output_req  (req),
`ifdef ENOC_CREDIT_EN
    .i_credit      (en_or_cr),
`else
    .i_en          (en_or_cr),
`endif
    .o_input_grant (grant),
    .o_output_val  (val),
    .o_sel         (sel)
  );

  typedef struct packed {
    logic [0:P-1]         grant;
    logic [0:P-1]         val;
    logic [0:P-1][SW-1:0] sel;
    logic [0:P-1]         sel_mask;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   tests = 0;
  int   fails = 0;

  // Reference state: per-output priority input and remaining downstream space.
  int m_ptr[P];
  int m_credit[P];

  // Stimulus for the next cycle: destination per input (-1 = idle).
  int cur_dest[P];
  bit cur_en[P];
  bit cur_cr[P];
  bit cur_rst;

  function automatic int rnd_dest();
    int r;
    r = int'($urandom_range(0, P + 2));
    return (r >= P) ? -1 : r;
  endfunction

  task automatic clear();
    for (int i = 0; i < P; i++) begin
      cur_dest[i] = -1;
      cur_en[i]   = 1'b1;
      cur_cr[i]   = 1'b0;
    end
    cur_rst = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = !cur_rst;
    for (int i = 0; i < P; i++) begin
      for (int o = 0; o < P; o++) begin
        req[i][o] = (cur_dest[i] == o);
      end
    end
    for (int o = 0; o < P; o++) begin
      en_or_cr[o] = USE_CREDIT ? cur_cr[o] : cur_en[o];
    end

    e = '0;
    if (cur_rst) begin
      e.sel_mask = '1;
      for (int o = 0; o < P; o++) begin
        m_ptr[o]    = 0;
        m_credit[o] = CR;
      end
    end else begin
      for (int o = 0; o < P; o++) begin
        bit ok;
        int win;
        ok  = USE_CREDIT ? (m_credit[o] > 0) : cur_en[o];
        win = -1;
        if (ok) begin
          for (int k = 0; k < P; k++) begin
            if (win < 0 && cur_dest[(m_ptr[o] + k) % P] == o) begin
              win = (m_ptr[o] + k) % P;
            end
          end
        end
        if (win >= 0) begin
          e.grant[win]  = 1'b1;
          e.val[o]      = 1'b1;
          e.sel[o]      = SW'(win);
          e.sel_mask[o] = 1'b1;
          m_ptr[o]      = (win + 1) % P;
        end
        if (USE_CREDIT) begin
          assert (!(cur_cr[o] && win < 0 && m_credit[o] == CR))
            else $error("credit return above capacity on output %0d", o);
          if (win >= 0 && !cur_cr[o]) begin
            m_credit[o]--;
          end else if (win < 0 && cur_cr[o] && m_credit[o] < CR) begin
            m_credit[o]++;
          end
        end
      end
    end
    sb.push_back(e);
    last_exp = e;
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    for (int i = 0; i < P; i++) begin
      assert ($countones(req[i]) <= 1) else $error("multi-hot request row %0d", i);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (grant !== e.grant) begin
        fails++;
        $display("FAIL input_grant: got %b expected %b", grant, e.grant);
      end
      tests++;
      if (val !== e.val) begin
        fails++;
        $display("FAIL output_val: got %b expected %b", val, e.val);
      end
      bad = 1'b0;
      for (int o = 0; o < P; o++) begin
        if (e.sel_mask[o] && (sel[o] !== e.sel[o])) begin
          bad = 1'b1;
        end
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL sel: got %h expected %h (mask %b)", sel, e.sel, e.sel_mask);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    req      = '0;
    en_or_cr = '0;
    for (int o = 0; o < P; o++) begin
      m_ptr[o]    = 0;
      m_credit[o] = CR;
    end

    // Reset with live requests: every output must stay 0.
    clear();
    cur_rst = 1'b1;
    for (int i = 0; i < P; i++) cur_dest[i] = rnd_dest();
    step();
    step();
    clear();
    step();

    // Single request: input 2 -> E, then 2 and 3 contend (pointer now 3).
    clear();
    cur_dest[2] = enoc_pkg::E;
    step();
    cur_dest[3] = enoc_pkg::E;
    step();
    cur_dest[3] = -1;
    step();

    // Fairness on N among inputs 0, 3, 6.
    clear();
    cur_dest[0] = enoc_pkg::N;
    cur_dest[3] = enoc_pkg::N;
    cur_dest[6] = enoc_pkg::N;
    repeat (6) step();

    if (!USE_CREDIT) begin
      // Backpressure on N, then release in the same cycle as the grant.
      clear();
      cur_dest[1] = enoc_pkg::N;
      cur_en[enoc_pkg::N] = 1'b0;
      repeat (2) step();
      cur_en[enoc_pkg::N] = 1'b1;
      step();
    end else begin
      // Credit exhaustion on S, then a single credit return.
      clear();
      cur_rst = 1'b1;
      step();
      clear();
      cur_dest[4] = enoc_pkg::S;
      repeat (6) step();
      cur_cr[enoc_pkg::S] = 1'b1;
      step();
      cur_cr[enoc_pkg::S] = 1'b0;
      repeat (3) step();
      // Grant and credit return together at credit = 1.
      clear();
      cur_rst = 1'b1;
      step();
      clear();
      cur_dest[4] = enoc_pkg::S;
      repeat (3) step();
      cur_cr[enoc_pkg::S] = 1'b1;
      step();
      cur_cr[enoc_pkg::S] = 1'b0;
      repeat (2) step();
    end

    // Reset mid-traffic, then contention restarts from pointer 0.
    clear();
    for (int i = 0; i < P; i++) cur_dest[i] = i % 3;
    repeat (3) step();
    cur_rst = 1'b1;
    step();
    cur_rst = 1'b0;
    repeat (2) step();

    // Randomised traffic; an input holds its request until granted.
    clear();
    for (int i = 0; i < P; i++) cur_dest[i] = rnd_dest();
    repeat (400) begin
      for (int o = 0; o < P; o++) begin
        cur_en[o] = ($urandom_range(0, 3) != 0);
        cur_cr[o] = (m_credit[o] < CR) && ($urandom_range(0, 2) == 0);
      end
      cur_rst = ($urandom_range(0, 99) == 0);
      step();
      for (int i = 0; i < P; i++) begin
        if (cur_dest[i] < 0 || last_exp.grant[i] || cur_rst) begin
          cur_dest[i] = rnd_dest();
        end
      end
    end

    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
